// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle arithmetic/logic ops and an optional shift-add multiplier.
// Define SEQ_ALU_MUL_EN to build the multiplier (opcode C); without it opcode C is reported as illegal.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] ac_in,
  input  logic [WIDTH-1:0] bus_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_INC  = 4'h2;
  localparam logic [3:0] OP_ADC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_PASS = 4'h8;
  localparam logic [3:0] OP_CLR  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;

  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_legal;

  // Shared adder: SUB is A + ~B + 1, INC is A + 0 + 1, ADC feeds back the carry flag.
  always_comb begin
    add_y   = bus_in;
    add_cin = 1'b0;
    case (op)
      OP_SUB: begin
        add_y   = ~bus_in;
        add_cin = 1'b1;
      end
      OP_INC: begin
        add_y   = '0;
        add_cin = 1'b1;
      end
      OP_ADC:  add_cin = flag_c;
      default: ;
    endcase
    add_sum = {1'b0, ac_in} + {1'b0, add_y} + (WIDTH+1)'(add_cin);
  end

  // Single-cycle result and carry/overflow; unlisted opcodes are illegal here.
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_legal = 1'b1;
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_ADC: begin
        alu_res = add_sum[MSB:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = (ac_in[MSB] == add_y[MSB]) && (add_sum[MSB] != ac_in[MSB]);
      end
      OP_AND:  alu_res = ac_in & bus_in;
      OP_OR:   alu_res = ac_in | bus_in;
      OP_XOR:  alu_res = ac_in ^ bus_in;
      OP_NOT:  alu_res = ~ac_in;
      OP_PASS: alu_res = bus_in;
      OP_CLR:  alu_res = '0;
      OP_SHL: begin
        alu_res = {ac_in[MSB-1:0], 1'b0};
        alu_c   = ac_in[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, ac_in[MSB:1]};
        alu_c   = ac_in[0];
      end
      default: alu_legal = 1'b0;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0]  OP_MUL = 4'hC;
  localparam int unsigned CNT_W  = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  // One shift-add step: prod_lo starts as the multiplier and is shifted out LSB first.
  always_comb begin
    mul_sum = {1'b0, prod_hi} + {1'b0, mcand & {WIDTH{prod_lo[0]}}};
    nxt_hi  = mul_sum[WIDTH:1];
    nxt_lo  = {mul_sum[0], prod_lo[MSB:1]};
  end
`else
  assign busy      = 1'b0;
  assign result_hi = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      state     <= S_IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      result_hi <= '0;
      mcand     <= '0;
      prod_hi   <= '0;
      prod_lo   <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      if (state == S_MUL) begin
        prod_hi <= nxt_hi;
        prod_lo <= nxt_lo;
        cnt     <= cnt + CNT_W'(1);
        // Last iteration: publish the product and return to IDLE in the same edge.
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cnt       <= '0;
          done      <= 1'b1;
          result    <= nxt_lo;
          result_hi <= nxt_hi;
          flag_z    <= ~|{nxt_hi, nxt_lo};
          flag_n    <= nxt_hi[MSB];
          flag_c    <= |nxt_hi;
          flag_v    <= 1'b0;
        end
      end else
`endif
      if (start) begin
`ifdef SEQ_ALU_MUL_EN
        if (op == OP_MUL) begin
          state   <= S_MUL;
          busy    <= 1'b1;
          cnt     <= '0;
          mcand   <= ac_in;
          prod_hi <= '0;
          prod_lo <= bus_in;
        end else
`endif
        if (alu_legal) begin
          done   <= 1'b1;
          result <= alu_res;
          flag_z <= ~|alu_res;
          flag_n <= alu_res[MSB];
          flag_c <= alu_c;
          flag_v <= alu_v;
`ifdef SEQ_ALU_MUL_EN
          result_hi <= '0;
`endif
        end else begin
          done <= 1'b1;
          err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed, table-driven bench for seq_alu at WIDTH=8.
// Multiplier sequences run only when SEQ_ALU_MUL_EN is defined; otherwise opcode C is checked as illegal.
module tb_seq_alu;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] ac_in;
  logic [W-1:0] bus_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .ac_in    (ac_in),
    .bus_in   (bus_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .result_hi(result_hi),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_c   (flag_c),
    .flag_v   (flag_v),
    .err      (err)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    logic         e;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] res, input logic [W-1:0] hi,
                              input logic z, input logic n, input logic c, input logic v,
                              input logic e);
    vec_t t;
    t.op = o; t.a = a; t.b = b; t.res = res; t.hi = hi;
    t.z = z; t.n = n; t.c = c; t.v = v; t.e = e;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic d, input logic e, input logic b,
                         input logic [W-1:0] r, input logic [W-1:0] h,
                         input logic z, input logic n, input logic c, input logic v);
    chk({tag, ".done"},      32'(done),      32'(d));
    chk({tag, ".err"},       32'(err),       32'(e));
    chk({tag, ".busy"},      32'(busy),      32'(b));
    chk({tag, ".result"},    32'(result),    32'(r));
    chk({tag, ".result_hi"}, 32'(result_hi), 32'(h));
    chk({tag, ".flag_z"},    32'(flag_z),    32'(z));
    chk({tag, ".flag_n"},    32'(flag_n),    32'(n));
    chk({tag, ".flag_c"},    32'(flag_c),    32'(c));
    chk({tag, ".flag_v"},    32'(flag_v),    32'(v));
  endtask

  // One request: drive at a falling edge, expect done in the cycle after the accepting edge.
  task automatic apply(input string tag, input vec_t t);
    @(negedge clk);
    chk({tag, ".pre_done"}, 32'(done), 32'(0));
    start = 1'b1; op = t.op; ac_in = t.a; bus_in = t.b;
    @(negedge clk);
    start = 1'b0;
    chk_out(tag, 1'b1, t.e, 1'b0, t.res, t.hi, t.z, t.n, t.c, t.v);
  endtask

`ifdef SEQ_ALU_MUL_EN
  task automatic mul_run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] lo, input logic [W-1:0] hi,
                         input logic z, input logic n, input logic c);
    int lat;
    @(negedge clk);
    start = 1'b1; op = 4'hC; ac_in = a; bus_in = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(W));
    chk_out(tag, 1'b1, 1'b0, 1'b0, lo, hi, z, n, c, 1'b0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    rst = 1'b1; start = 1'b0; op = 4'h0; ac_in = '0; bus_in = '0;

    //            op    A      B      res    hi     z     n     c     v     err
    vecs.push_back(mk(4'h0, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(4'h1, 8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'h3, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'h2, 8'h7F, 8'h00, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(4'h1, 8'h03, 8'h05, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'h3, 8'h10, 8'h20, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'h4, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'h5, 8'hF0, 8'h0F, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'h6, 8'hAA, 8'hAA, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'h7, 8'h0F, 8'h33, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'h8, 8'h00, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'h9, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'hA, 8'h81, 8'h00, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'hB, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'hE, 8'h55, 8'h66, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(4'h0, 8'h80, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(4'hF, 8'h01, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(4'h0, 8'hFF, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'hB, 8'h80, 8'h00, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'h1, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(4'h3, 8'h7F, 8'h00, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(4'h7, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

`ifndef SEQ_ALU_MUL_EN
    // Without the multiplier, opcode C must look like any other illegal opcode.
    apply("mul_off", mk(4'hC, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
`endif

    // Back-to-back: second start is held through the first done cycle.
    @(negedge clk);
    start = 1'b1; op = 4'hA; ac_in = 8'h81; bus_in = 8'h00;
    @(negedge clk);
    chk_out("b2b_shl", 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    op = 4'hB; ac_in = 8'h01;
    @(negedge clk);
    start = 1'b0;
    chk_out("b2b_shr", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b_after.done", 32'(done), 32'(0));

    // Reset wins over a simultaneous start.
    apply("pre_rst", mk(4'h8, 8'h00, 8'hC3, 8'hC3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 4'h0; ac_in = 8'h01; bus_in = 8'h01;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk_out("rst_prio", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_prio_after.done", 32'(done), 32'(0));

`ifdef SEQ_ALU_MUL_EN
    // 0xFF * 0xFF with a stray ADD request held during busy.
    @(negedge clk);
    start = 1'b1; op = 4'hC; ac_in = 8'hFF; bus_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("mul_ff_busy%0d", k), 32'({busy, done}), 32'(2'b10));
      if (k >= 1 && k <= 6) begin
        start = 1'b1; op = 4'h0; ac_in = 8'h01; bus_in = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk_out("mul_ff", 1'b1, 1'b0, 1'b0, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("mul_ff_after.done", 32'(done), 32'(0));
    chk("mul_ff_after.result", 32'(result), 32'(8'h01));

    mul_run("mul_3x5",   8'h03, 8'h05, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0);
    mul_run("mul_10x10", 8'h10, 8'h10, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1);
    mul_run("mul_0x37",  8'h00, 8'h37, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    mul_run("mul_10x10b", 8'h10, 8'h10, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1);
    apply("hi_clear", mk(4'h0, 8'h01, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Reset in the 4th busy cycle aborts the multiply without a done pulse.
    mul_run("mul_pre", 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b1; op = 4'hC; ac_in = 8'h10; bus_in = 8'h10;
    @(negedge clk);
    start = 1'b0;
    chk("mul_abort.busy", 32'(busy), 32'(1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_out("mul_abort", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    chk("mul_abort.no_done", 32'(stray), 32'(0));
`endif

    apply("fresh_add", mk(4'h0, 8'h01, 8'h02, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 4..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, operation request.
REQ-005 The block SHALL have port op, input, 4 bits, opcode sampled with start.
REQ-006 The block SHALL have port ac_in, input, WIDTH bits, accumulator operand A.
REQ-007 The block SHALL have port bus_in, input, WIDTH bits, bus operand B.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a multi-cycle operation runs.
REQ-009 The block SHALL have port done, output, 1 bit, one-cycle pulse marking result valid.
REQ-010 The block SHALL have port result, output, WIDTH bits, registered result (low half for MUL).
REQ-011 The block SHALL have port result_hi, output, WIDTH bits, high half of MUL product, else 0.
REQ-012 The block SHALL have ports flag_z, flag_n, flag_c, flag_v, outputs, 1 bit each, registered zero/negative/carry/overflow.
REQ-013 The block SHALL have port err, output, 1 bit, high with done when the opcode was illegal.

Function
REQ-014 A request SHALL be accepted on a rising edge where start=1 and busy=0; op, ac_in, bus_in are captured at that edge; start while busy=1 SHALL be ignored.
REQ-015 Opcodes: 0 ADD A+B; 1 SUB A+~B+1; 2 INC A+1; 3 ADC A+B+flag_c; 4 AND; 5 OR; 6 XOR; 7 NOT A; 8 PASS B; 9 CLR 0; A SHL A<<1; B SHR logical A>>1; C MUL A*B unsigned; D-F illegal.
REQ-016 Single-cycle ops SHALL update result and flags at the accepting edge and assert done=1 for exactly the following cycle; busy stays 0.
REQ-017 State machine: IDLE (accept), MUL (busy=1, WIDTH shift-add iterations, counter 0..WIDTH-1); MUL->IDLE on the edge completing iteration WIDTH-1, which also loads result/result_hi/flags and asserts done for one cycle with busy=0.
REQ-018 MUL latency SHALL be exactly WIDTH clocks from the accepting edge to the edge loading the result; busy is high for WIDTH cycles.
REQ-019 A start asserted in the cycle done=1 SHALL be accepted (back-to-back, no bubble).
REQ-020 Arithmetic is modulo 2^WIDTH; flag_c = carry out of bit WIDTH-1 for ADD/ADC/INC/SUB (SUB: 1 means no borrow); SHL flag_c = old A[WIDTH-1]; SHR flag_c = old A[0].
REQ-021 flag_v SHALL be signed overflow for ADD/ADC/SUB/INC, else 0; logic, PASS, CLR ops SHALL clear flag_c and flag_v.
REQ-022 flag_z SHALL be 1 iff result (and result_hi for MUL) is all zero; flag_n = MSB of result (MUL: MSB of result_hi).
REQ-023 MUL flag_c SHALL be 1 iff result_hi is nonzero; flag_v=0.
REQ-024 Illegal opcode SHALL pulse done and err together one cycle after acceptance, leaving result, result_hi and flags unchanged.
REQ-025 result_hi SHALL be cleared by every non-MUL legal op.

Reset
REQ-026 rst=1 at a rising edge SHALL force state IDLE, busy=0, done=0, err=0, result=0, result_hi=0, all flags 0, counter 0.
REQ-027 rst during MUL SHALL abort it with no done pulse; rst has priority over start in the same cycle.

Configuration
REQ-028 Macro SEQ_ALU_MUL_EN defined: MUL state, counter and product registers present, opcode C legal per REQ-017/018.
REQ-029 SEQ_ALU_MUL_EN undefined: no MUL hardware, busy tied 0, result_hi tied 0, opcode C treated as illegal per REQ-024.

Verification (WIDTH=8)
REQ-030 ADD A=0x7F B=0x01 -> next cycle done=1, result=0x80, N=1, V=1, C=0, Z=0.
REQ-031 SUB A=0x05 B=0x05 -> result=0x00, Z=1, C=1, V=0; then ADC A=0xFF B=0x00 -> result=0x00, C=1, Z=1.
REQ-032 MUL (macro on) A=0xFF B=0xFF -> busy 8 cycles, done 8 clocks after accept, result=0x01, result_hi=0xFE, C=1; start during busy ignored.
REQ-033 rst asserted at 4th MUL cycle -> next cycle all outputs 0, no done; fresh ADD then completes normally.
REQ-034 Opcode E, and opcode C with macro off -> done=1, err=1, prior result/flags held.
REQ-035 Back-to-back: SHL A=0x81 then start held in done cycle with SHR A=0x01 -> results 0x02 C=1, then 0x00 C=1 Z=1, done high two consecutive cycles.
